// File: rtl/btb_assoc_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btb_assoc_if : lookup/update/flush bundle for btb_assoc.        Rev 1.0
// ---------------------------------------------------------------------------
interface btb_assoc_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_lookup;
  logic            lookup_en;
  logic            update_en;
  logic [XLEN-1:0] pc_update;
  logic [XLEN-1:0] target_actual;
  logic [1:0]      br_type_update;
  logic            taken_actual;
  logic            flush_req;
  logic            hit;
  logic [XLEN-1:0] target_predicted;
  logic [1:0]      br_type_predicted;
  logic            flush_busy;

  modport master (
    output pc_lookup, lookup_en, update_en, pc_update, target_actual,
           br_type_update, taken_actual, flush_req,
    input  hit, target_predicted, br_type_predicted, flush_busy
  );

  modport slave (
    input  pc_lookup, lookup_en, update_en, pc_update, target_actual,
           br_type_update, taken_actual, flush_req,
    output hit, target_predicted, br_type_predicted, flush_busy
  );
endinterface
`default_nettype wire

// File: rtl/btb_assoc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btb_assoc : set-associative BTB, round-robin victim, swept flush.  Rev 1.0
// ---------------------------------------------------------------------------
module btb_assoc #(
  parameter int XLEN     = 32,
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  btb_assoc_if.slave  bus
);
  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int TAG_W   = XLEN - INDEX_W - 2;
  localparam logic [1:0] BR_COND = 2'b00;
  localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(NUM_SETS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Assertion is immediate; release is re-timed onto the clk rising edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n_int = rst_sync_q[1];

  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d  [NUM_SETS];
  logic [TAG_W-1:0]    tag_q    [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_d    [NUM_SETS][NUM_WAYS];
  logic [XLEN-1:0]     target_q [NUM_SETS][NUM_WAYS];
  logic [XLEN-1:0]     target_d [NUM_SETS][NUM_WAYS];
  logic [1:0]          type_q   [NUM_SETS][NUM_WAYS];
  logic [1:0]          type_d   [NUM_SETS][NUM_WAYS];

  state_e              state_q, state_d;
  logic [INDEX_W-1:0]  flush_idx_q, flush_idx_d;
  logic                flush_busy;
  logic                flush_clr;

  assign flush_busy = (state_q == ST_FLUSH);
  assign flush_clr  = flush_busy;

  // ---------------------------------------------------------------- lookup
  logic [INDEX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic [NUM_WAYS-1:0] lk_match;
  logic [WAY_W-1:0]    lk_way;
  logic                lk_single;
  logic                lk_hit;

  assign lk_idx = bus.pc_lookup[INDEX_W+1:2];
  assign lk_tag = bus.pc_lookup[XLEN-1:INDEX_W+2];

  always_comb begin
    lk_match = '0;
    lk_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_match[w] = 1'b1;
        lk_way      = WAY_W'(w);
      end
    end
  end

  // A duplicated tag is treated as a miss rather than muxing two ways.
  assign lk_single = (lk_match != '0) &&
                     ((lk_match & (lk_match - NUM_WAYS'(1))) == '0);
  assign lk_hit    = bus.lookup_en && !flush_busy && lk_single;

  assign bus.hit               = lk_hit;
  assign bus.target_predicted  = lk_hit ? target_q[lk_idx][lk_way]
                                        : bus.pc_lookup + XLEN'(4);
  assign bus.br_type_predicted = lk_hit ? type_q[lk_idx][lk_way] : BR_COND;
  assign bus.flush_busy        = flush_busy;

  // ---------------------------------------------------------------- update
  logic [INDEX_W-1:0]  up_idx;
  logic [TAG_W-1:0]    up_tag;
  logic [NUM_WAYS-1:0] up_match;
  logic [WAY_W-1:0]    up_way;
  logic [WAY_W-1:0]    free_way;
  logic                has_free;
  logic [WAY_W-1:0]    victim_cur;
  logic                up_ok;
  logic                wr_en;
  logic [WAY_W-1:0]    wr_way;
  logic                victim_adv;

  assign up_idx = bus.pc_update[INDEX_W+1:2];
  assign up_tag = bus.pc_update[XLEN-1:INDEX_W+2];

  always_comb begin
    up_match = '0;
    up_way   = '0;
    free_way = '0;
    has_free = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
        up_match[w] = 1'b1;
        up_way      = WAY_W'(w);
      end
    end
    // Walk downward so the lowest-index invalid way is the one that sticks.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[up_idx][w]) begin
        free_way = WAY_W'(w);
        has_free = 1'b1;
      end
    end
  end

  // A flush request sampled in IDLE takes priority over a concurrent update.
  assign up_ok = bus.update_en && (state_q == ST_IDLE) && !bus.flush_req;

  always_comb begin
    wr_en      = 1'b0;
    wr_way     = up_way;
    victim_adv = 1'b0;
    if (up_ok) begin
      if (up_match != '0) begin
        if (bus.taken_actual || (bus.br_type_update != BR_COND)) wr_en = 1'b1;
      end else if (bus.taken_actual) begin
        wr_en = 1'b1;
        if (has_free) begin
          wr_way = free_way;
        end else begin
          wr_way     = victim_cur;
          victim_adv = 1'b1;
        end
      end
    end
  end

  // ----------------------------------------------------------- flush FSM
  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.flush_req) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush_idx_d = flush_idx_q + INDEX_W'(1);
        if (flush_idx_q == LAST_SET) begin
          state_d     = ST_IDLE;
          flush_idx_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= ST_IDLE;
      flush_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
    end
  end

  // ------------------------------------------------------------- storage
  always_comb begin
    valid_d = valid_q;
    if (flush_clr) valid_d[flush_idx_q] = '0;
    if (wr_en)     valid_d[up_idx][wr_way] = 1'b1;
  end

  always_comb begin
    tag_d    = tag_q;
    target_d = target_q;
    type_d   = type_q;
    if (wr_en) begin
      tag_d[up_idx][wr_way]    = up_tag;
      target_d[up_idx][wr_way] = bus.target_actual;
      type_d[up_idx][wr_way]   = bus.br_type_update;
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) valid_q <= '{default: '0};
    else            valid_q <= valid_d;
  end

  // Payload arrays carry no reset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    type_q   <= type_d;
  end

  generate
    if (NUM_WAYS > 1) begin : g_victim
      logic [WAY_W-1:0] victim_q [NUM_SETS];
      logic [WAY_W-1:0] victim_d [NUM_SETS];

      always_comb begin
        victim_d = victim_q;
        if (flush_clr)       victim_d[flush_idx_q] = '0;
        else if (victim_adv) victim_d[up_idx] = victim_q[up_idx] + WAY_W'(1);
      end

      always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) victim_q <= '{default: '0};
        else            victim_q <= victim_d;
      end

      assign victim_cur = victim_q[up_idx];
    end else begin : g_no_victim
      assign victim_cur = '0;
    end
  endgenerate

  logic unused_ok;
  assign unused_ok = ^{bus.pc_update[1:0], victim_adv};

endmodule
`default_nettype wire

// File: tb/tb_btb_assoc.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_btb_assoc : directed bench for btb_assoc (16 sets, 2 ways).   Rev 1.0
// ---------------------------------------------------------------------------
module tb_btb_assoc;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  btb_assoc_if #(.XLEN(XLEN)) bus ();

  btb_assoc #(
    .XLEN     (XLEN),
    .NUM_SETS (16),
    .NUM_WAYS (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                         input logic [1:0] ty, input logic tk);
    bus.update_en      = 1'b1;
    bus.pc_update      = pc;
    bus.target_actual  = tgt;
    bus.br_type_update = ty;
    bus.taken_actual   = tk;
  endtask

  task automatic clr_upd();
    bus.update_en    = 1'b0;
    bus.taken_actual = 1'b0;
  endtask

  task automatic do_update(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                           input logic [1:0] ty, input logic tk);
    set_upd(pc, tgt, ty, tk);
    tick();
    clr_upd();
  endtask

  task automatic look(input string tag, input logic [XLEN-1:0] pc,
                      input logic exp_hit, input logic [XLEN-1:0] exp_tgt,
                      input logic [1:0] exp_ty);
    bus.pc_lookup = pc;
    bus.lookup_en = 1'b1;
    #1;
    check({tag, "_hit"},  bus.hit,               exp_hit);
    check({tag, "_tgt"},  bus.target_predicted,  exp_tgt);
    check({tag, "_type"}, bus.br_type_predicted, exp_ty);
  endtask

  task automatic look_miss(input string tag, input logic [XLEN-1:0] pc);
    look(tag, pc, 1'b0, pc + 32'd4, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen_hit;

    reset_n            = 1'b0;
    bus.pc_lookup      = 32'h40;
    bus.lookup_en      = 1'b1;
    bus.update_en      = 1'b0;
    bus.pc_update      = '0;
    bus.target_actual  = '0;
    bus.br_type_update = 2'b00;
    bus.taken_actual   = 1'b0;
    bus.flush_req      = 1'b0;

    // Reset state
    #2;
    check("rst_busy", bus.flush_busy, 1'b0);
    look_miss("rst", 32'h40);
    tick(); tick();
    reset_n = 1'b1;
    repeat (4) tick();

    // Basic hit / miss
    do_update(32'h100, 32'h200, 2'b01, 1'b1);
    look("basic", 32'h100, 1'b1, 32'h200, 2'b01);
    look_miss("basic_nb", 32'h104);

    // No same-cycle bypass
    tick();
    set_upd(32'h188, 32'h400, 2'b10, 1'b1);
    look_miss("bypass_same", 32'h188);
    tick();
    clr_upd();
    look("bypass_next", 32'h188, 1'b1, 32'h400, 2'b10);

    // Replacement in set 0
    do_update(32'h500, 32'h1500, 2'b01, 1'b1);
    do_update(32'h900, 32'h1900, 2'b01, 1'b1);
    look_miss("repl_100", 32'h100);
    look("repl_500", 32'h500, 1'b1, 32'h1500, 2'b01);
    look("repl_900", 32'h900, 1'b1, 32'h1900, 2'b01);
    do_update(32'hD00, 32'h1D00, 2'b01, 1'b1);
    look_miss("repl2_500", 32'h500);
    look("repl2_D00", 32'hD00, 1'b1, 32'h1D00, 2'b01);
    look("repl2_900", 32'h900, 1'b1, 32'h1900, 2'b01);

    // Hit update overwrites but leaves the victim pointer alone
    do_update(32'h900, 32'h2900, 2'b00, 1'b1);
    look("hitupd_900", 32'h900, 1'b1, 32'h2900, 2'b00);
    do_update(32'hE00, 32'h1E00, 2'b01, 1'b1);
    look_miss("vict_900", 32'h900);
    look("vict_D00", 32'hD00, 1'b1, 32'h1D00, 2'b01);
    look("vict_E00", 32'hE00, 1'b1, 32'h1E00, 2'b01);

    // Not-taken behaviour
    do_update(32'hD00, 32'h300, 2'b00, 1'b0);
    look("nt_cond", 32'hD00, 1'b1, 32'h1D00, 2'b01);
    do_update(32'h188, 32'h700, 2'b11, 1'b0);
    look("nt_ret", 32'h188, 1'b1, 32'h700, 2'b11);
    do_update(32'h10C, 32'h800, 2'b01, 1'b0);
    look_miss("nt_noalloc", 32'h10C);

    // Flush sweep
    for (int s = 0; s < 16; s++)
      do_update(32'h2000 + 32'(s) * 4, 32'h3000 + 32'(s) * 4, 2'b01, 1'b1);
    look("fill_s0",  32'h2000, 1'b1, 32'h3000, 2'b01);
    look("fill_s15", 32'h203C, 1'b1, 32'h303C, 2'b01);
    tick();
    bus.flush_req = 1'b1;
    set_upd(32'h4004, 32'h5000, 2'b01, 1'b1);
    bus.pc_lookup = 32'h2000;
    #1;
    check("flush_busy_pre", bus.flush_busy, 1'b0);
    tick();
    bus.flush_req = 1'b0;
    clr_upd();
    n = 0;
    seen_hit = 1'b0;
    while (bus.flush_busy && n < 40) begin
      n++;
      if (bus.hit) seen_hit = 1'b1;
      if (n == 3) begin
        bus.flush_req = 1'b1;
        set_upd(32'h4008, 32'h5008, 2'b01, 1'b1);
      end else begin
        bus.flush_req = 1'b0;
        clr_upd();
      end
      bus.pc_lookup = 32'h2000 + 32'(n % 16) * 4;
      tick();
    end
    bus.flush_req = 1'b0;
    clr_upd();
    check("flush_cycles", 32'(n), 32'd16);
    check("flush_hit_during", {31'd0, seen_hit}, 32'd0);
    look_miss("postflush_s0",  32'h2000);
    look_miss("postflush_s15", 32'h203C);
    look_miss("postflush_s2",  32'h188);
    look_miss("flush_upd_lost", 32'h4004);
    look_miss("busy_upd_lost",  32'h4008);
    tick();
    check("flush_no_restart", bus.flush_busy, 1'b0);

    // Reset in the middle of a flush
    do_update(32'h2000, 32'h3000, 2'b01, 1'b1);
    do_update(32'h2010, 32'h3010, 2'b01, 1'b1);
    do_update(32'h203C, 32'h303C, 2'b01, 1'b1);
    look("prerst_s15", 32'h203C, 1'b1, 32'h303C, 2'b01);
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    repeat (4) tick();
    check("busy_cycle5", bus.flush_busy, 1'b1);
    #2;
    reset_n = 1'b0;
    bus.pc_lookup = 32'h203C;
    #1;
    check("rstmid_busy", bus.flush_busy, 1'b0);
    look_miss("rstmid", 32'h203C);
    tick(); tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("rstrel_busy", bus.flush_busy, 1'b0);
    look_miss("rstrel_s0",  32'h2000);
    look_miss("rstrel_s4",  32'h2010);
    look_miss("rstrel_s15", 32'h203C);
    do_update(32'h2020, 32'h3020, 2'b10, 1'b1);
    look("rstrel_alloc", 32'h2020, 1'b1, 32'h3020, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL provide parameter XLEN, default 32: address and target width.
REQ-002 SHALL provide parameter NUM_SETS, default 16: set count, power of two, range 2..256; INDEX_W = log2(NUM_SETS).
REQ-003 SHALL provide parameter NUM_WAYS, default 2: associativity, power of two, range 1..4.
REQ-004 SHALL derive TAG_W = XLEN-INDEX_W-2; index = pc[INDEX_W+1:2], tag = pc[XLEN-1:INDEX_W+2].
REQ-005 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pc_lookup, input, XLEN: fetch PC from IF stage.
REQ-008 SHALL have port lookup_en, input, 1: lookup qualifier.
REQ-009 SHALL have port update_en, input, 1: resolved-control-flow update from EX stage.
REQ-010 SHALL have port pc_update, input, XLEN: PC of the resolved instruction.
REQ-011 SHALL have port target_actual, input, XLEN: resolved target.
REQ-012 SHALL have port br_type_update, input, 2: 00 COND, 01 JAL, 10 JALR, 11 RET.
REQ-013 SHALL have port taken_actual, input, 1: resolved direction.
REQ-014 SHALL have port flush_req, input, 1: single-cycle pulse requesting a full invalidate.
REQ-015 SHALL have port hit, output, 1: lookup hit.
REQ-016 SHALL have port target_predicted, output, XLEN: predicted target.
REQ-017 SHALL have port br_type_predicted, output, 2: stored type of the hitting entry.
REQ-018 SHALL have port flush_busy, output, 1: high while the flush sweep runs.

Function
REQ-019 SHALL hold per way per set: valid bit, TAG_W tag, XLEN target, 2-bit type; SHALL hold per set a log2(NUM_WAYS)-bit round-robin victim pointer (absent when NUM_WAYS=1).
REQ-020 SHALL perform the lookup combinationally in the same cycle; hit=1 when lookup_en=1, flush_busy=0, and exactly one valid way in the indexed set has a matching tag.
REQ-021 SHALL drive, on hit, target_predicted and br_type_predicted from the hitting way; on miss, SHALL drive target_predicted = pc_lookup+4 (modulo 2^XLEN) and br_type_predicted = 00.
REQ-022 SHALL make writes visible from the cycle after the update edge; there SHALL be no same-cycle write-to-read bypass.
REQ-023 SHALL, on an update edge (update_en=1, flush_busy=0) with a tag match in the update set, overwrite that way's target and type when taken_actual=1 or type!=COND, and SHALL leave the victim pointer unchanged.
REQ-024 SHALL, on an update edge with a tag match where taken_actual=0 and type=COND, leave the entry unchanged (no eviction on not-taken).
REQ-025 SHALL, on an update edge with no tag match and taken_actual=1, allocate the lowest-index invalid way; if every way is valid, it SHALL allocate the way at the victim pointer and advance that pointer by 1, wrapping NUM_WAYS-1 to 0.
REQ-026 SHALL ignore an update with no tag match and taken_actual=0.
REQ-027 SHALL implement a two-state FSM. IDLE -> FLUSH on flush_req=1. In FLUSH, it SHALL clear every way's valid bit and the victim pointer of set flush_idx on each cycle, with flush_idx incrementing from 0. FLUSH -> IDLE after clearing set NUM_SETS-1.
REQ-028 SHALL assert flush_busy exactly while in FLUSH: NUM_SETS cycles, starting the cycle after flush_req is sampled.
REQ-029 SHALL ignore flush_req while in FLUSH, with no restart.
REQ-030 SHALL discard an update presented in the same cycle that flush_req is sampled in IDLE; flush wins.
REQ-031 SHALL NOT queue updates presented while flush_busy=1; they SHALL be dropped.

Reset
REQ-032 SHALL, on reset_n low, asynchronously clear all valid bits, all victim pointers, flush_idx and the FSM (to IDLE). Tag, target and type arrays SHALL NOT be reset.
REQ-033 SHALL present these outputs while reset_n is low: hit=0, flush_busy=0, br_type_predicted=00, target_predicted=pc_lookup+4.
REQ-034 SHALL abort a flush in progress on reset assertion and return to IDLE; release SHALL be synchronous to the clk rising edge.

Verification (NUM_SETS=16, NUM_WAYS=2, XLEN=32)
REQ-035 SHALL cover basic hit: update pc=0x100, target=0x200, type JAL, taken=1; lookup 0x100 next cycle -> hit=1, target 0x200, type 01; lookup 0x104 -> hit=0, target 0x108.
REQ-036 SHALL cover same-cycle write then read: update and lookup of 0x100 in the same cycle -> hit=0; next cycle -> hit=1.
REQ-037 SHALL cover replacement: allocate 0x100, 0x500, 0x900 (all set 0, taken=1) -> 0x900 replaces way 0 (0x100 misses; 0x500 and 0x900 hit); allocating 0xD00 then replaces way 1 (0x500).
REQ-038 SHALL cover not-taken COND: hit on 0x100 with COND, taken=0, target 0x300 -> entry still predicts its old target; an unallocated pc with taken=0 -> no allocation.
REQ-039 SHALL cover flush: fill sets 0..15, pulse flush_req together with an update -> flush_busy high for exactly 16 cycles, all lookups miss during and after, the concurrent update is absent.
REQ-040 SHALL cover reset mid-flush: assert reset_n low at flush cycle 5 -> flush_busy=0 immediately; after release, state is IDLE and all entries miss.
